// File: rtl/dcs_eci_tx_mux.sv
// Three-source round-robin merge of ECI response/forward packets into one registered output stage.
// Optional per-source saturating packet counters on tx_cnt_o when DCS_ECI_TX_MUX_PERF_CNT_EN is defined.

package eci_cmd_defs;
    localparam int ECI_WORD_WIDTH        = 64;
    localparam int ECI_PACKET_SIZE       = 17;
    localparam int ECI_PACKET_SIZE_WIDTH = 5;
endpackage

module dcs_eci_tx_mux
    import eci_cmd_defs::*;
#(
    parameter int PERF_REGS_WIDTH = 32
) (
    input  logic                                             eci_clk,
    input  logic                                             eci_reset,
    input  logic [ECI_WORD_WIDTH-1:0]                        rsp_wod_hdr_i,
    input  logic [ECI_PACKET_SIZE_WIDTH-1:0]                 rsp_wod_pkt_size_i,
    input  logic [3:0]                                       rsp_wod_pkt_vc_i,
    input  logic                                             rsp_wod_pkt_valid_i,
    output logic                                             rsp_wod_pkt_ready_o,
    input  logic [ECI_PACKET_SIZE-1:0][ECI_WORD_WIDTH-1:0]   rsp_wd_pkt_i,
    input  logic [ECI_PACKET_SIZE_WIDTH-1:0]                 rsp_wd_pkt_size_i,
    input  logic [3:0]                                       rsp_wd_pkt_vc_i,
    input  logic                                             rsp_wd_pkt_valid_i,
    output logic                                             rsp_wd_pkt_ready_o,
    input  logic [ECI_WORD_WIDTH-1:0]                        fwd_wod_hdr_i,
    input  logic [ECI_PACKET_SIZE_WIDTH-1:0]                 fwd_wod_pkt_size_i,
    input  logic [3:0]                                       fwd_wod_pkt_vc_i,
    input  logic                                             fwd_wod_pkt_valid_i,
    output logic                                             fwd_wod_pkt_ready_o,
    output logic [ECI_PACKET_SIZE-1:0][ECI_WORD_WIDTH-1:0]   eci_tx_pkt_o,
    output logic [ECI_PACKET_SIZE_WIDTH-1:0]                 eci_tx_pkt_size_o,
    output logic [3:0]                                       eci_tx_pkt_vc_o,
    output logic                                             eci_tx_pkt_valid_o,
    input  logic                                             eci_tx_pkt_ready_i
`ifdef DCS_ECI_TX_MUX_PERF_CNT_EN
    ,
    output logic [2:0][PERF_REGS_WIDTH-1:0]                  tx_cnt_o
`endif
);

    typedef logic [ECI_PACKET_SIZE-1:0][ECI_WORD_WIDTH-1:0] pkt_t;

    logic [2:0]                       src_vld;
    logic [2:0]                       src_rdy;
    logic [1:0]                       last_grant;
    logic [1:0]                       grant_idx;
    logic [1:0]                       cand;
    logic                             grant_vld;
    logic                             load;
    pkt_t                             nxt_pkt;
    logic [ECI_PACKET_SIZE_WIDTH-1:0] nxt_size;
    logic [3:0]                       nxt_vc;

    if (PERF_REGS_WIDTH < 1) begin : g_bad_perf_width
    end

    assign src_vld = {fwd_wod_pkt_valid_i, rsp_wd_pkt_valid_i, rsp_wod_pkt_valid_i};
    assign load    = !eci_tx_pkt_valid_o || eci_tx_pkt_ready_i;

    // Walk last_grant+1 .. last_grant+3 (mod 3); first valid source wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant;
        cand      = last_grant;
        for (int i = 0; i < 3; i++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!grant_vld && src_vld[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        src_rdy = 3'b000;
        if (load && grant_vld && !eci_reset) begin
            src_rdy[grant_idx] = 1'b1;
        end
    end

    assign rsp_wod_pkt_ready_o = src_rdy[0];
    assign rsp_wd_pkt_ready_o  = src_rdy[1];
    assign fwd_wod_pkt_ready_o = src_rdy[2];

    // Header-only sources occupy word 0; the remaining words are zero-filled.
    always_comb begin
        nxt_pkt  = '0;
        nxt_size = '0;
        nxt_vc   = '0;
        case (grant_idx)
            2'd0: begin
                nxt_pkt[0] = rsp_wod_hdr_i;
                nxt_size   = rsp_wod_pkt_size_i;
                nxt_vc     = rsp_wod_pkt_vc_i;
            end
            2'd1: begin
                nxt_pkt  = rsp_wd_pkt_i;
                nxt_size = rsp_wd_pkt_size_i;
                nxt_vc   = rsp_wd_pkt_vc_i;
            end
            2'd2: begin
                nxt_pkt[0] = fwd_wod_hdr_i;
                nxt_size   = fwd_wod_pkt_size_i;
                nxt_vc     = fwd_wod_pkt_vc_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge eci_clk or posedge eci_reset) begin
        if (eci_reset) begin
            eci_tx_pkt_valid_o <= 1'b0;
            eci_tx_pkt_o       <= '0;
            eci_tx_pkt_size_o  <= '0;
            eci_tx_pkt_vc_o    <= '0;
            last_grant         <= 2'd2;
        end else if (load) begin
            eci_tx_pkt_valid_o <= grant_vld;
            if (grant_vld) begin
                eci_tx_pkt_o      <= nxt_pkt;
                eci_tx_pkt_size_o <= nxt_size;
                eci_tx_pkt_vc_o   <= nxt_vc;
                last_grant        <= grant_idx;
            end
        end
    end

`ifdef DCS_ECI_TX_MUX_PERF_CNT_EN
    for (genvar k = 0; k < 3; k++) begin : g_cnt
        always_ff @(posedge eci_clk or posedge eci_reset) begin
            if (eci_reset) begin
                tx_cnt_o[k] <= '0;
            end else if (src_rdy[k] && tx_cnt_o[k] != {PERF_REGS_WIDTH{1'b1}}) begin
                tx_cnt_o[k] <= tx_cnt_o[k] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcs_eci_tx_mux.sv
// Directed bench for dcs_eci_tx_mux: table of arbitration steps plus stall, reset and counter sequences.
`timescale 1ns/1ps

module tb_dcs_eci_tx_mux;
    import eci_cmd_defs::*;

    typedef logic [ECI_PACKET_SIZE-1:0][ECI_WORD_WIDTH-1:0] pkt_t;

    localparam logic [63:0] HDR0 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] HDR2 = 64'hC2C2_0000_5555_0002;
    localparam logic [63:0] WD_BASE = 64'h1111_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    logic [63:0] rsp_wod_hdr;
    logic [4:0]  rsp_wod_size;
    logic [3:0]  rsp_wod_vc;
    logic        rsp_wod_vld;
    logic        rsp_wod_rdy;
    pkt_t        rsp_wd_pkt;
    logic [4:0]  rsp_wd_size;
    logic [3:0]  rsp_wd_vc;
    logic        rsp_wd_vld;
    logic        rsp_wd_rdy;
    logic [63:0] fwd_hdr;
    logic [4:0]  fwd_size;
    logic [3:0]  fwd_vc;
    logic        fwd_vld;
    logic        fwd_rdy;
    pkt_t        tx_pkt;
    logic [4:0]  tx_size;
    logic [3:0]  tx_vc;
    logic        tx_vld;
    logic        tx_rdy;
`ifdef DCS_ECI_TX_MUX_PERF_CNT_EN
    logic [2:0][3:0] tx_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dcs_eci_tx_mux #(.PERF_REGS_WIDTH(4)) dut (
        .eci_clk             (clk),
        .eci_reset           (rst),
        .rsp_wod_hdr_i       (rsp_wod_hdr),
        .rsp_wod_pkt_size_i  (rsp_wod_size),
        .rsp_wod_pkt_vc_i    (rsp_wod_vc),
        .rsp_wod_pkt_valid_i (rsp_wod_vld),
        .rsp_wod_pkt_ready_o (rsp_wod_rdy),
        .rsp_wd_pkt_i        (rsp_wd_pkt),
        .rsp_wd_pkt_size_i   (rsp_wd_size),
        .rsp_wd_pkt_vc_i     (rsp_wd_vc),
        .rsp_wd_pkt_valid_i  (rsp_wd_vld),
        .rsp_wd_pkt_ready_o  (rsp_wd_rdy),
        .fwd_wod_hdr_i       (fwd_hdr),
        .fwd_wod_pkt_size_i  (fwd_size),
        .fwd_wod_pkt_vc_i    (fwd_vc),
        .fwd_wod_pkt_valid_i (fwd_vld),
        .fwd_wod_pkt_ready_o (fwd_rdy),
        .eci_tx_pkt_o        (tx_pkt),
        .eci_tx_pkt_size_o   (tx_size),
        .eci_tx_pkt_vc_o     (tx_vc),
        .eci_tx_pkt_valid_o  (tx_vld),
        .eci_tx_pkt_ready_i  (tx_rdy)
`ifdef DCS_ECI_TX_MUX_PERF_CNT_EN
        ,
        .tx_cnt_o            (tx_cnt)
`endif
    );

    typedef struct {
        logic       v0, v1, v2, rdy;
        logic [2:0] exp_rdy;   // {src2, src1, src0}
        logic       exp_vld;
        int         exp_src;
    } vec_t;

    vec_t vecs[15];

    function automatic pkt_t exp_pkt(int src);
        pkt_t p = '0;
        if (src == 0) p[0] = HDR0;
        else if (src == 2) p[0] = HDR2;
        else if (src == 1) for (int k = 0; k < ECI_PACKET_SIZE; k++) p[k] = WD_BASE + 64'(k);
        return p;
    endfunction

    function automatic logic [4:0] exp_size(int src);
        return (src == 0) ? 5'd1 : (src == 1) ? 5'd17 : 5'd2;
    endfunction

    function automatic logic [3:0] exp_vc(int src);
        return (src == 0) ? 4'd5 : (src == 1) ? 4'd3 : 4'd9;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int src);
        int bad = -1;
        pkt_t e = exp_pkt(src);
        checks++;
        for (int k = 0; k < ECI_PACKET_SIZE; k++)
            if (bad < 0 && tx_pkt[k] !== e[k]) bad = k;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s pkt word %0d: got 0x%0h expected 0x%0h", name, bad, tx_pkt[bad], e[bad]);
        end
        chk({name, " size"}, 64'(tx_size), 64'(exp_size(src)));
        chk({name, " vc"}, 64'(tx_vc), 64'(exp_vc(src)));
    endtask

    task automatic drive(input logic v0, input logic v1, input logic v2, input logic r);
        rsp_wod_vld = v0;
        rsp_wd_vld  = v1;
        fwd_vld     = v2;
        tx_rdy      = r;
    endtask

    function automatic logic [63:0] rdys();
        return 64'({fwd_rdy, rsp_wd_rdy, rsp_wod_rdy});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rsp_wod_hdr = HDR0; rsp_wod_size = 5'd1;  rsp_wod_vc = 4'd5;
        fwd_hdr     = HDR2; fwd_size     = 5'd2;  fwd_vc     = 4'd9;
        rsp_wd_size = 5'd17; rsp_wd_vc = 4'd3;
        for (int k = 0; k < ECI_PACKET_SIZE; k++) rsp_wd_pkt[k] = WD_BASE + 64'(k);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        //           v0    v1    v2    rdy   exp_rdy  vld  src
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, 1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 2};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 3};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 2};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 2};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, 1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 3};

        #1;
        chk("reset valid", 64'(tx_vld), 64'd0);
        chk("reset size", 64'(tx_size), 64'd0);
        chk("reset vc", 64'(tx_vc), 64'd0);
        chk("reset word0", tx_pkt[0], 64'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("reset readies", rdys(), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d readies", i), rdys(), 64'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d valid", i), 64'(tx_vld), 64'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) chk_out($sformatf("vec%0d", i), vecs[i].exp_src);
            @(negedge clk);
        end

        // Stall with a source-1 packet latched while every source requests.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk_out("stall load", 1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("stall%0d readies", c), rdys(), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d valid", c), 64'(tx_vld), 64'd1);
            chk_out($sformatf("stall%0d", c), 1);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("unstall readies", rdys(), 64'd0);
        @(posedge clk); #1;
        chk("unstall drained", 64'(tx_vld), 64'd0);
        @(negedge clk);

        // Reset while FULL and stalled; readies stay low despite a pending load.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk_out("prerst load", 2);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("prerst held", 64'(tx_vld), 64'd1);
        rst = 1'b1;
        tx_rdy = 1'b1;
        #1;
        chk("rst drops valid", 64'(tx_vld), 64'd0);
        chk("rst readies", rdys(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("postrst readies", rdys(), 64'b001);
        @(posedge clk); #1;
        chk_out("postrst", 0);
        @(negedge clk);

`ifdef DCS_ECI_TX_MUX_PERF_CNT_EN
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("cnt2 saturated", 64'(tx_cnt[2]), 64'd15);
        chk("cnt0", 64'(tx_cnt[0]), 64'd0);
        chk("cnt1", 64'(tx_cnt[1]), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
